// File: rtl/banco_registro_multi.sv
// Multi-port register file with one write port, optional zero register,
// and a one-entry-per-cycle soft-clear sweep (busy / wr_drop flags).
// Ports: clk, rst (sync, active-low), addrR/datOutR (N_RD packed read ports),
//   addrW/datW/RegWrite (write port), clr_req (start sweep), busy, wr_drop.
// Build option: define BANCO_BYPASS_EN for same-cycle write-through reads.
module banco_registro_multi #(
  parameter int BIT_ADDR = 3,
  parameter int BIT_DATO = 4,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*BIT_ADDR-1:0] addrR,
  output logic [N_RD*BIT_DATO-1:0] datOutR,
  input  logic [BIT_ADDR-1:0]      addrW,
  input  logic [BIT_DATO-1:0]      datW,
  input  logic                     RegWrite,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int NREG = 1 << BIT_ADDR;
  localparam logic [BIT_ADDR-1:0] LAST = BIT_ADDR'(NREG - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t              state;
  logic [BIT_ADDR-1:0] ptr;
  logic [BIT_DATO-1:0] breg [NREG];

  // Writes to entry 0 vanish when it is the hard-wired zero register.
  logic wr_ok;
  assign wr_ok = !((ZERO_REG != 0) && (addrW == '0));

`ifdef BANCO_BYPASS_EN
  logic fwd;
  assign fwd = RegWrite && (state == IDLE) && wr_ok;
`endif

  genvar k;
  for (k = 0; k < N_RD; k++) begin : g_rd
    logic [BIT_ADDR-1:0] a;
    logic [BIT_DATO-1:0] d;
    assign a = addrR[k*BIT_ADDR +: BIT_ADDR];
    always_comb begin
      d = breg[a];
      if ((ZERO_REG != 0) && (a == '0))
        d = '0;
`ifdef BANCO_BYPASS_EN
      if (fwd && (a == addrW))
        d = datW;
`endif
    end
    assign datOutR[k*BIT_DATO +: BIT_DATO] = d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      busy    <= 1'b0;
      wr_drop <= 1'b0;
      for (int i = 0; i < NREG; i++)
        breg[i] <= '0;
    end else begin
      wr_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (RegWrite && wr_ok)
            breg[addrW] <= datW;
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          breg[ptr] <= '0;
          ptr       <= ptr + BIT_ADDR'(1);
          if (RegWrite)
            wr_drop <= 1'b1;
          if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/banco_registro_multi.md
Name: banco_registro_multi

Overview:
- Parametrised register file, successor to the single-write/dual-read bank.
- Provides N_RD combinational read ports, one write port and an optional hard-wired zero register.
- Adds a soft-clear sequencer that sweeps the array one entry per cycle, with a busy flag.
- Sits between the datapath ALU and the operand/display logic of the lab designs.

Parameters:
- BIT_ADDR, 3, address width; NREG = 2**BIT_ADDR entries.
- BIT_DATO, 4, data width per entry.
- N_RD, 2, number of read ports (1..8).
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- addrR  in  N_RD*BIT_ADDR  read addresses, port k at bits [k*BIT_ADDR +: BIT_ADDR].
- datOutR  out  N_RD*BIT_DATO  read data, port k at bits [k*BIT_DATO +: BIT_DATO].
- addrW  in  BIT_ADDR  write address.
- datW  in  BIT_DATO  write data.
- RegWrite  in  1  write enable.
- clr_req  in  1  soft-clear request; single-cycle pulse or level.
- busy  out  1  high while the clear sweep runs.
- wr_drop  out  1  registered one-cycle pulse when a write was discarded.

Behaviour:
- Reset: rst=0 at a clock edge clears every entry to 0 in that same cycle.
  - Forces state IDLE, busy=0, wr_drop=0, sweep pointer=0.
  - Reset has priority over everything, including mid-sweep and writes.
- Read path:
  - datOutR port k = breg[addrR_k], combinational, no latency.
  - Read of an address written this cycle returns the OLD value unless BYPASS_EN (below).
  - With ZERO_REG=1, any port addressing 0 returns 0.
- Write path in IDLE:
  - RegWrite=1 stores datW into breg[addrW] at the edge; visible on reads the next cycle.
  - With ZERO_REG=1, a write to addr 0 is silently ignored; wr_drop stays 0.
- FSM states IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req=1. On that same edge: ptr<=0, busy<=1. Any RegWrite in that cycle is still performed.
  - In CLEAR, each cycle: breg[ptr]<=0 and ptr<=ptr+1.
  - When ptr==NREG-1, the final entry is cleared, state returns to IDLE and busy<=0.
  - A full sweep therefore holds busy high for exactly NREG cycles.
  - clr_req while in CLEAR is ignored; there is no restart.
  - clr_req held high after the sweep completes starts a new sweep on the next edge.
- Writes while busy=1 (including the last CLEAR cycle):
  - The write is not performed.
  - wr_drop=1 for the following cycle only.
- Reads while busy return current array contents, some entries already cleared.
- Widths:
  - ptr is BIT_ADDR bits wide; it wraps from NREG-1 to 0 only at sweep end.
  - No arithmetic is performed on the data.

Optional Feature:
- Macro: BANCO_BYPASS_EN.
- Defined: if RegWrite=1, state IDLE, the write is not suppressed by ZERO_REG, and addrR_k==addrW, then datOutR port k = datW in the same cycle (write-through forwarding).
- Not defined: reads always show stored contents, so the new value appears one cycle later.
- Array update timing is identical in both builds.

Test Plan:
- Reset and basic write: rst=0 for 1 cycle, then write 5->addr3 and 9->addr7. Required: all ports read 0 after reset; addr3 reads 5 and addr7 reads 9 from the next cycle.
- Multi-port read: N_RD=2, addrR={7,3} after the writes above. Required: datOutR={9,5}; both addresses set to 3 -> both ports read 5.
- Soft clear: fill all 8 entries with 0xF, pulse clr_req. Required: busy high for exactly 8 cycles; entry i reads 0 from cycle i+1; busy=0 afterwards.
- Write during clear: RegWrite=1, addr2, data 6 on sweep cycle 4. Required: wr_drop=1 on the next cycle only; addr2 stays 0.
- Reset mid-sweep: rst=0 on sweep cycle 3. Required: busy=0 next cycle, all entries 0, a subsequent write to addr1 succeeds.
- ZERO_REG=1 and bypass: write 4->addr0. Required: addr0 reads 0, wr_drop=0. With BANCO_BYPASS_EN, write 0xA->addr5 while addrR0=5: datOutR0=0xA in the same cycle; without the macro it shows the old value until the next cycle.
